// File: rtl/clk_gen_adj.sv
// -----------------------------------------------------------------------------
// clk_gen_adj
//
// Clock and timing generator for the modem. From clk_in it derives the
// system clock (clk_in/2), sample and symbol rate square waves, one-sys_clk
// wide clock enables and a symbol-phase count in sys_clk units. Timing
// recovery can shorten or lengthen a single symbol by one sys_clk period,
// and a sync request restarts the symbol phase at zero.
//
// Parameters:
//   SAM_DIV  sys_clk cycles per sample (>= 2)
//   SPS      samples per symbol (>= 1)
//   PHASE_W  width of clk_phase, 2**PHASE_W >= SAM_DIV*SPS
//
// Ports:
//   clk_in       in   master clock
//   reset        in   asynchronous, active-high
//   adv_req      in   pulse: shorten the next symbol by one sys_clk period
//   ret_req      in   pulse: lengthen the next symbol by one sys_clk period
//   sync_req     in   pulse: restart the symbol phase at 0
//   sys_clk      out  clk_in/2, registered
//   sam_clk      out  sample-rate square wave
//   sym_clk      out  symbol-rate square wave
//   sam_clk_ena  out  one sys_clk period high per sample
//   sym_clk_ena  out  one sys_clk period high per symbol
//   clk_phase    out  symbol phase, 0..N-1 (N = SAM_DIV*SPS)
//   adj_busy     out  an advance or retard is pending
//   adj_ack      out  one clk_in pulse when an adjustment is applied
//
// Build option:
//   CLK_GEN_ADJ_EN  when defined, advance/retard handling is built in.
//                   When undefined, adv_req/ret_req are ignored, adj_busy
//                   and adj_ack stay 0 and the phase counts modulo N.
//                   Sync works in both builds.
// -----------------------------------------------------------------------------
module clk_gen_adj #(
    parameter int SAM_DIV = 4,
    parameter int SPS     = 4,
    parameter int PHASE_W = 4
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               adv_req,
    input  logic               ret_req,
    input  logic               sync_req,
    output logic               sys_clk,
    output logic               sam_clk,
    output logic               sym_clk,
    output logic               sam_clk_ena,
    output logic               sym_clk_ena,
    output logic [PHASE_W-1:0] clk_phase,
    output logic               adj_busy,
    output logic               adj_ack
);

    localparam int N = SAM_DIV * SPS;

    localparam logic [PHASE_W-1:0] PH_ZERO = '0;
    localparam logic [PHASE_W-1:0] PH_ONE  = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               sys_clk_reg, sys_clk_next;
    logic               h_reg, h_next;
    logic [PHASE_W-1:0] ph_reg, ph_next;
    logic               sync_p_reg, sync_p_next;

`ifdef CLK_GEN_ADJ_EN
    logic               adv_p_reg, adv_p_next;
    logic               ret_p_reg, ret_p_next;
    logic               hold_reg, hold_next;
    logic               ack_reg, ack_next;
`else
    // Adjustment inputs have no function in this build.
    logic               unused_adj;
    assign unused_adj = adv_req ^ ret_req;
`endif

    // The phase advances only on every second clk_in edge, i.e. once per
    // sys_clk period; h_reg==1 marks that edge.
    logic step_edge;
    assign step_edge = h_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        h_next       = ~h_reg;
        sys_clk_next = ~sys_clk_reg;
        ph_next      = ph_reg;
        sync_p_next  = sync_p_reg;
`ifdef CLK_GEN_ADJ_EN
        adv_p_next   = adv_p_reg;
        ret_p_next   = ret_p_reg;
        hold_next    = hold_reg;
        ack_next     = 1'b0;
`endif

        if (step_edge) begin
            if (sync_p_reg) begin
                // Sync wins over any pending adjustment and discards it.
                ph_next     = PH_ZERO;
                sync_p_next = 1'b0;
`ifdef CLK_GEN_ADJ_EN
                adv_p_next  = 1'b0;
                ret_p_next  = 1'b0;
                hold_next   = 1'b0;
`endif
            end
`ifdef CLK_GEN_ADJ_EN
            else if (hold_reg) begin
                // Second sys_clk period at phase 0 of a retarded symbol.
                ph_next   = PH_ZERO;
                hold_next = 1'b0;
            end
`endif
            else if (ph_reg == PH_LAST) begin
                ph_next = PH_ZERO;
`ifdef CLK_GEN_ADJ_EN
                // Adjustments land on the wrap so that only phase 0 is
                // skipped or doubled; phase 0 never carries an enable.
                if (adv_p_reg) begin
                    ph_next    = PH_ONE;
                    adv_p_next = 1'b0;
                    ack_next   = 1'b1;
                end else if (ret_p_reg) begin
                    hold_next  = 1'b1;
                    ret_p_next = 1'b0;
                    ack_next   = 1'b1;
                end
`endif
            end else begin
                ph_next = ph_reg + PH_ONE;
            end
        end

`ifdef CLK_GEN_ADJ_EN
        // Request capture works on the flags as left by this edge's
        // application step, so a request arriving on the applying edge
        // becomes pending for the following symbol. Opposite requests
        // cancel each other; a repeat of the pending kind changes nothing.
        if (!(step_edge && sync_p_reg)) begin
            if (adv_req && !ret_req) begin
                if (ret_p_next) begin
                    ret_p_next = 1'b0;
                end else begin
                    adv_p_next = 1'b1;
                end
            end else if (ret_req && !adv_req) begin
                if (adv_p_next) begin
                    adv_p_next = 1'b0;
                end else begin
                    ret_p_next = 1'b1;
                end
            end
        end
`endif

        if (sync_req) begin
            sync_p_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sys_clk_reg <= 1'b0;
            h_reg       <= 1'b0;
            ph_reg      <= PH_ZERO;
            sync_p_reg  <= 1'b0;
`ifdef CLK_GEN_ADJ_EN
            adv_p_reg   <= 1'b0;
            ret_p_reg   <= 1'b0;
            hold_reg    <= 1'b0;
            ack_reg     <= 1'b0;
`endif
        end else begin
            sys_clk_reg <= sys_clk_next;
            h_reg       <= h_next;
            ph_reg      <= ph_next;
            sync_p_reg  <= sync_p_next;
`ifdef CLK_GEN_ADJ_EN
            adv_p_reg   <= adv_p_next;
            ret_p_reg   <= ret_p_next;
            hold_reg    <= hold_next;
            ack_reg     <= ack_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Phase decodes
    // ------------------------------------------------------------------
    logic [31:0] ph_ext;
    logic [31:0] sam_pos;

    assign ph_ext  = 32'(ph_reg);
    assign sam_pos = ph_ext % 32'(SAM_DIV);

    assign sam_clk_ena = (sam_pos == 32'(SAM_DIV - 1));
    assign sam_clk     = (sam_pos < 32'(SAM_DIV / 2));
    assign sym_clk_ena = (ph_reg == PH_LAST);
    assign sym_clk     = (ph_ext < 32'(N / 2));

    assign sys_clk   = sys_clk_reg;
    assign clk_phase = ph_reg;

`ifdef CLK_GEN_ADJ_EN
    assign adj_busy = adv_p_reg | ret_p_reg;
    assign adj_ack  = ack_reg;
`else
    assign adj_busy = 1'b0;
    assign adj_ack  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_gen_adj.sv
// -----------------------------------------------------------------------------
// tb_clk_gen_adj
//
// Two instances: A at the defaults (N=16) and B with SAM_DIV=3, SPS=5
// (N=15). The stimulus process pushes one expected record per symbol
// (period in clk_in cycles, sample-enable pulses, acks, phase after the
// symbol enable) into a queue; the monitor pops and compares a record at
// every rising sym_clk_ena. A few direct checks cover reset values,
// start-up phase sequence and adj_busy latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_gen_adj;

`ifdef CLK_GEN_ADJ_EN
    localparam int ADJ = 1;
`else
    localparam int ADJ = 0;
`endif

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic reset_a, adv_a, ret_a, sync_a;
    logic sys_a, sam_a, sym_a, sam_ena_a, sym_ena_a, busy_a, ack_a;
    logic [3:0] phase_a;

    logic reset_b, adv_b, ret_b, sync_b;
    logic sys_b, sam_b, sym_b, sam_ena_b, sym_ena_b, busy_b, ack_b;
    logic [3:0] phase_b;

    clk_gen_adj #(.SAM_DIV(4), .SPS(4), .PHASE_W(4)) u_a (
        .clk_in(clk_in), .reset(reset_a),
        .adv_req(adv_a), .ret_req(ret_a), .sync_req(sync_a),
        .sys_clk(sys_a), .sam_clk(sam_a), .sym_clk(sym_a),
        .sam_clk_ena(sam_ena_a), .sym_clk_ena(sym_ena_a),
        .clk_phase(phase_a), .adj_busy(busy_a), .adj_ack(ack_a)
    );

    clk_gen_adj #(.SAM_DIV(3), .SPS(5), .PHASE_W(4)) u_b (
        .clk_in(clk_in), .reset(reset_b),
        .adv_req(adv_b), .ret_req(ret_b), .sync_req(sync_b),
        .sys_clk(sys_b), .sam_clk(sam_b), .sym_clk(sym_b),
        .sam_clk_ena(sam_ena_b), .sym_clk_ena(sym_ena_b),
        .clk_phase(phase_b), .adj_busy(busy_b), .adj_ack(ack_b)
    );

    typedef struct {
        int period;
        int sams;
        int acks;
        int nph;
    } sym_t;

    sym_t q_a[$];
    sym_t q_b[$];

    int vectors     = 0;
    int miscompares = 0;
    int toggle_bad  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    // {sys, sam, sym, sam_ena, sym_ena, busy, ack, phase}
    function automatic int outs(input int d);
        if (d == 0)
            return {21'd0, sys_a, sam_a, sym_a, sam_ena_a, sym_ena_a, busy_a, ack_a, phase_a};
        return {21'd0, sys_b, sam_b, sym_b, sam_ena_b, sym_ena_b, busy_b, ack_b, phase_b};
    endfunction

    // {phase, sys, sam_ena, sam_clk, sym_clk, sym_ena}
    function automatic int sig(input int d);
        if (d == 0)
            return {23'd0, phase_a, sys_a, sam_ena_a, sam_a, sym_a, sym_ena_a};
        return {23'd0, phase_b, sys_b, sam_ena_b, sam_b, sym_b, sym_ena_b};
    endfunction

    function automatic logic sym_ena(input int d);
        return (d == 0) ? sym_ena_a : sym_ena_b;
    endfunction

    task automatic push(input int d, input int period, input int sams, input int acks, input int nph);
        sym_t e;
        e.period = period;
        e.sams   = sams;
        e.acks   = acks;
        e.nph    = nph;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // All stimulus runs at negedge+1.
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic pulse(input int d, input logic a, input logic r, input logic s);
        if (d == 0) begin adv_a = a; ret_a = r; sync_a = s; end
        else        begin adv_b = a; ret_b = r; sync_b = s; end
        @(negedge clk_in);
        #1;
        if (d == 0) begin adv_a = 1'b0; ret_a = 1'b0; sync_a = 1'b0; end
        else        begin adv_b = 1'b0; ret_b = 1'b0; sync_b = 1'b0; end
    endtask

    task automatic wait_rise(input int d, output int n);
        logic prev;
        logic cur;
        prev = sym_ena(d);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            #1;
            n++;
            cur = sym_ena(d);
            if (cur && !prev) return;
            prev = cur;
        end
        timeout($sformatf("%s sym_clk_ena rise", (d == 0) ? "A" : "B"));
        n = -1;
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 300; i++) begin
            if (((d == 0) ? q_a.size() : q_b.size()) == 0) return;
            @(negedge clk_in);
            #1;
        end
        timeout($sformatf("%s scoreboard drain", (d == 0) ? "A" : "B"));
    endtask

    // ------------------------------------------------------------------
    // Monitor: per-symbol measurements, compared at each sym_clk_ena rise
    // ------------------------------------------------------------------
    initial begin : monitor
        int   cnt[2], sams[2], acks[2], nph[2];
        logic have_prev[2], prev_sym[2], prev_sam[2];
        logic prev_sys, sys_valid;
        logic rst, se, sa, ak;
        logic [3:0] ph;
        logic found;
        sym_t e;
        string tag;
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; sams[d] = 0; acks[d] = 0; nph[d] = 0;
            have_prev[d] = 1'b0; prev_sym[d] = 1'b0; prev_sam[d] = 1'b0;
        end
        prev_sys  = 1'b0;
        sys_valid = 1'b0;
        forever begin
            @(negedge clk_in);
            if (reset_a) begin
                sys_valid = 1'b0;
            end else begin
                if (sys_valid && (sys_a == prev_sys)) toggle_bad++;
                prev_sys  = sys_a;
                sys_valid = 1'b1;
            end
            for (int d = 0; d < 2; d++) begin
                rst = (d == 0) ? reset_a   : reset_b;
                se  = (d == 0) ? sym_ena_a : sym_ena_b;
                sa  = (d == 0) ? sam_ena_a : sam_ena_b;
                ak  = (d == 0) ? ack_a     : ack_b;
                ph  = (d == 0) ? phase_a   : phase_b;
                tag = (d == 0) ? "A" : "B";
                if (rst) begin
                    have_prev[d] = 1'b0;
                    prev_sym[d]  = 1'b0;
                    prev_sam[d]  = 1'b0;
                end else begin
                    cnt[d]++;
                    if (sa && !prev_sam[d]) sams[d]++;
                    if (ak) acks[d]++;
                    if (!se && prev_sym[d]) nph[d] = int'(ph);
                    if (se && !prev_sym[d]) begin
                        found = 1'b0;
                        if (have_prev[d]) begin
                            if (d == 0 && q_a.size() > 0) begin e = q_a.pop_front(); found = 1'b1; end
                            if (d == 1 && q_b.size() > 0) begin e = q_b.pop_front(); found = 1'b1; end
                        end
                        if (found) begin
                            chk($sformatf("%s symbol period", tag), cnt[d], e.period);
                            chk($sformatf("%s sam_clk_ena pulses", tag), sams[d], e.sams);
                            chk($sformatf("%s adj_ack pulses", tag), acks[d], e.acks);
                            chk($sformatf("%s phase after sym_clk_ena", tag), nph[d], e.nph);
                        end
                        have_prev[d] = 1'b1;
                        cnt[d]  = 0;
                        sams[d] = 0;
                        acks[d] = 0;
                    end
                    prev_sym[d] = se;
                    prev_sam[d] = sa;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Indexed by phase 0..9.
    logic [0:9] a_sam_ena = 10'b0001000100;
    logic [0:9] a_sam_clk = 10'b1100110011;
    logic [0:9] a_sym_clk = 10'b1111111100;
    logic [0:9] b_sam_ena = 10'b0010010010;
    logic [0:9] b_sam_clk = 10'b1001001001;
    logic [0:9] b_sym_clk = 10'b1111111000;

    localparam int RST_OUTS = {21'd0, 7'b0110000, 4'd0};

    initial begin : stimulus
        int n, k, exp_a, exp_b;
        reset_a = 1'b1; reset_b = 1'b1;
        adv_a = 1'b0; ret_a = 1'b0; sync_a = 1'b0;
        adv_b = 1'b0; ret_b = 1'b0; sync_b = 1'b0;

        #2;
        chk("A reset outputs", outs(0), RST_OUTS);
        chk("B reset outputs", outs(1), RST_OUTS);

        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Start-up: after edge e, phase = e/2 and sys_clk = e%2.
        for (int e = 1; e <= 19; e++) begin
            @(negedge clk_in);
            #1;
            k = e / 2;
            exp_a = (k << 5) | ((e % 2) << 4) | (int'(a_sam_ena[k]) << 3)
                  | (int'(a_sam_clk[k]) << 2) | (int'(a_sym_clk[k]) << 1);
            exp_b = (k << 5) | ((e % 2) << 4) | (int'(b_sam_ena[k]) << 3)
                  | (int'(b_sam_clk[k]) << 2) | (int'(b_sym_clk[k]) << 1);
            chk($sformatf("A startup edge %0d", e), sig(0), exp_a);
            chk($sformatf("B startup edge %0d", e), sig(1), exp_b);
        end

        // First symbol enable of A at edge 2(N-1) = 30.
        wait_rise(0, n);
        chk("A first sym_clk_ena edge", n + 19, 30);

        // Free run
        push(0, 32, 4, 0, 0);
        push(0, 32, 4, 0, 0);
        drain(0);

        // Advance
        wait_rise(0, n);
        push(0, 32, 4, 0, 0);
        wait_cycles(10);
        pulse(0, 1'b1, 1'b0, 1'b0);
        chk("A adj_busy after adv_req", int'(busy_a), ADJ);
        push(0, (ADJ != 0) ? 30 : 32, 4, ADJ, ADJ);
        drain(0);
        chk("A adj_busy after advance", int'(busy_a), 0);

        // Retard
        wait_rise(0, n);
        push(0, 32, 4, 0, 0);
        wait_cycles(10);
        pulse(0, 1'b0, 1'b1, 1'b0);
        chk("A adj_busy after ret_req", int'(busy_a), ADJ);
        push(0, (ADJ != 0) ? 34 : 32, 4, ADJ, 0);
        drain(0);
        chk("A adj_busy after retard", int'(busy_a), 0);

        // adv_req and ret_req together
        wait_rise(0, n);
        push(0, 32, 4, 0, 0);
        push(0, 32, 4, 0, 0);
        wait_cycles(10);
        pulse(0, 1'b1, 1'b1, 1'b0);
        chk("A adj_busy after simultaneous reqs", int'(busy_a), 0);
        drain(0);

        // adv_req then ret_req cancels
        wait_rise(0, n);
        push(0, 32, 4, 0, 0);
        push(0, 32, 4, 0, 0);
        wait_cycles(8);
        pulse(0, 1'b1, 1'b0, 1'b0);
        chk("A adj_busy after adv before cancel", int'(busy_a), ADJ);
        wait_cycles(2);
        pulse(0, 1'b0, 1'b1, 1'b0);
        chk("A adj_busy after cancelling ret_req", int'(busy_a), 0);
        drain(0);

        // Sync at phase 9 with an advance pending: 2 + 20 + 30 cycles
        wait_rise(0, n);
        push(0, 52, 6, 0, 0);
        wait_cycles(4);
        pulse(0, 1'b1, 1'b0, 1'b0);
        chk("A adj_busy before sync", int'(busy_a), ADJ);
        k = 0;
        while (phase_a != 4'd9 && k < 64) begin
            wait_cycles(1);
            k++;
        end
        if (k >= 64) timeout("A reach phase 9");
        pulse(0, 1'b0, 1'b0, 1'b1);
        chk("A phase while sync pending", int'(phase_a), 9);
        wait_cycles(1);
        chk("A phase after sync", int'(phase_a), 0);
        chk("A adj_busy after sync", int'(busy_a), 0);
        drain(0);

        // B: free run (adv_req ignored without the adjustment build)
        wait_rise(1, n);
        push(1, 30, 5, 0, 0);
        push(1, 30, 5, 0, 0);
`ifndef CLK_GEN_ADJ_EN
        wait_cycles(6);
        pulse(1, 1'b1, 1'b0, 1'b0);
        chk("B adj_busy after ignored adv_req", int'(busy_b), 0);
`endif
        drain(1);

        // B: asynchronous reset mid-symbol
        wait_rise(1, n);
        wait_cycles(7);
        #2;
        reset_b = 1'b1;
        #1;
        chk("B outputs during mid-symbol reset", outs(1), RST_OUTS);
        @(negedge clk_in);
        #1;
        chk("B outputs held in reset", outs(1), RST_OUTS);
        reset_b = 1'b0;
        wait_rise(1, n);
        chk("B first sym_clk_ena edge after reset", n, 28);
        push(1, 30, 5, 0, 0);
        drain(1);

        chk("A sys_clk toggle errors", toggle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_gen_adj.md
# clk_gen_adj

Parametrised successor to the fixed 50 MHz divider chain. From `clk_in` it generates the system clock, sample and symbol clocks, their clock enables and a symbol-phase count. Oversampling ratio and sample divide are set by parameters. Symbol timing can be advanced or retarded by one `sys_clk` period per symbol, driven by timing recovery, and a sync request realigns the symbol phase. It sits at the top of the modem and feeds every sampled and symbol-rate block.

## Interface
- `SAM_DIV`, default 4: `sys_clk` cycles per sample; must be ≥ 2.
- `SPS`, default 4: samples per symbol; must be ≥ 1.
- `PHASE_W`, default 4: width of `clk_phase`; requires 2^PHASE_W ≥ N, where N = SAM_DIV*SPS.
- `clk_in`  in  1: master clock, nominally 50 MHz.
- `reset`  in  1: asynchronous, active-high.
- `adv_req`  in  1: one-cycle pulse; shorten the next symbol by one `sys_clk` period.
- `ret_req`  in  1: one-cycle pulse; lengthen the next symbol by one `sys_clk` period.
- `sync_req`  in  1: one-cycle pulse; restart the symbol phase at 0.
- `sys_clk`  out  1: `clk_in`/2, registered.
- `sam_clk`  out  1: sample-rate square wave.
- `sym_clk`  out  1: symbol-rate square wave.
- `sam_clk_ena`  out  1: one `sys_clk` period wide, once per sample.
- `sym_clk_ena`  out  1: one `sys_clk` period wide, once per symbol.
- `clk_phase`  out  PHASE_W: symbol phase in `sys_clk` units, range 0..N-1.
- `adj_busy`  out  1: an advance or retard is pending.
- `adj_ack`  out  1: one `clk_in` pulse when an adjustment is applied.

## Operation
- Internal state:
  - half-cycle bit `h`;
  - phase counter `ph` (PHASE_W bits), driving `clk_phase`;
  - pending flags `adv_p` and `ret_p`;
  - sync flag `sync_p`.
- Every `clk_in` edge toggles `sys_clk` and `h`.
- `ph` updates only on edges where `h==1` (the "step edge"):
  - Normal: `ph` = (`ph`==N-1) ? 0 : `ph`+1.
- Decodes, all combinational from `ph`:
  - `sam_clk_ena` = (`ph` mod SAM_DIV == SAM_DIV-1).
  - `sym_clk_ena` = (`ph` == N-1).
  - `sam_clk` = (`ph` mod SAM_DIV < SAM_DIV/2), integer divide.
  - `sym_clk` = (`ph` < N/2), integer divide.
- Request capture, on any `clk_in` edge:
  - `adv_req` sets `adv_p`; `ret_req` sets `ret_p`.
  - Both requests in the same cycle: both ignored.
  - A request matching the already-pending kind: ignored (at most one adjustment per symbol).
  - The opposite kind while one is pending: clears the pending flag. Net: no adjustment, no ack.
- Application, at the step edge with `ph`==N-1:
  - `adv_p`: `ph` goes to 1, skipping 0.
  - `ret_p`: `ph` goes to 0 and a hold flag keeps `ph`=0 on the following step edge.
  - In both cases the pending flag clears and `adj_ack` pulses for one `clk_in` cycle.
- Because SAM_DIV ≥ 2, phase 0 never carries an enable, so adjustment never adds or drops an enable pulse.
- Sync:
  - `sync_req` sets `sync_p`.
  - At the next step edge, `ph` is forced to 0, and `sync_p`, `adv_p`, `ret_p` and the hold flag are cleared; no ack.
  - Sync takes priority over adjustment at the same edge.
- `adj_busy` = `adv_p | ret_p`.

## Timing
- Reset values: `sys_clk`=0, `h`=0, `ph`=0, all flags 0. Outputs are therefore `sam_clk`=1, `sym_clk`=1, both enables 0, `clk_phase`=0, `adj_busy`=0, `adj_ack`=0.
- Edges are counted from the first `clk_in` rise after reset deassertion.
  - `ph` = k after edge 2k.
  - Unadjusted symbol period: 2N `clk_in` cycles (32 at defaults).
  - `sym_clk_ena` is high from edge 2(N-1) through edge 2N-1.
- Timing of adjusted symbols:
  - Advanced symbol: 2N-2 cycles.
  - Retarded symbol: 2N+2 cycles.
- Request latency:
  - A request is visible on `adj_busy` one `clk_in` cycle after it is sampled.
  - A request sampled at or after the applying step edge waits for the next symbol.
- Reset mid-operation asynchronously returns all state to the reset values.

## Configuration
- Macro: `CLK_GEN_ADJ_EN`.
- Defined: advance, retard and pending logic behave as described above.
- Undefined:
  - `adv_req` and `ret_req` are ignored.
  - `adj_busy`=0 and `adj_ack`=0 permanently.
  - `ph` counts purely modulo N.
- `sync_req` is unaffected by the macro.

## Test plan
- Defaults, free run after reset → `clk_phase` 0..15, `sym_clk_ena` every 32 cycles, `sam_clk_ena` at `ph` 3, 7, 11, 15, `sys_clk` toggling every edge.
- `adv_req` mid-symbol → `adj_busy`=1 next cycle; that symbol lasts 30 cycles, `clk_phase` goes 15→1, one `adj_ack`, `adj_busy`=0.
- `ret_req` → symbol lasts 34 cycles, `clk_phase` goes 15→0→0→1, enable count unchanged.
- `adv_req` and `ret_req` in the same cycle; also `adv_req` then `ret_req` a few cycles apart → no adjustment, no `adj_ack`, 32-cycle symbols.
- `sync_req` at `ph`=9 with `adv_p` set → `ph`=0 at the next step edge, `adj_busy`=0, no `adj_ack`.
- SAM_DIV=3, SPS=5 (N=15), macro undefined → 30-cycle symbols, `sam_clk_ena` at `ph` 2, 5, 8, 11, 14, `adv_req` ignored; reset asserted mid-symbol → all outputs return to reset values.
